// File: rtl/ters_sutun_karistirma.sv
// ters_sutun_karistirma: iterative AES InvMixColumns, one column per clock through a single shared column multiplier
module ters_sutun_karistirma (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         giris_gecerli,
  output logic         giris_hazir,
  input  logic [127:0] matris,
  output logic         cikis_gecerli,
  input  logic         cikis_hazir,
  output logic [127:0] y_matris
);
  typedef enum logic [1:0] {BOS, ISLE, HAZIR} durum_t;
  durum_t durum, sonraki;
  logic [1:0] sayac;
  logic [127:0] is_reg;
  logic [31:0] sutun, sonuc;
  logic [6:0] ust;
  logic al;
  logic [7:0] s [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // column c occupies bits [127-32c -: 32]; 127-32c equals {~c, 5'h1f}
  assign ust = {~sayac, 5'h1f};
  assign sutun = is_reg[ust -: 32];
  for (genvar g = 0; g < 4; g++) begin : g_kat
    assign s[g]  = sutun[31-8*g -: 8];
    assign x2[g] = xt(s[g]);
    assign x4[g] = xt(x2[g]);
    assign x8[g] = xt(x4[g]);
    assign m9[g] = x8[g] ^ s[g];
    assign mb[g] = x8[g] ^ x2[g] ^ s[g];
    assign md[g] = x8[g] ^ x4[g] ^ s[g];
    assign me[g] = x8[g] ^ x4[g] ^ x2[g];
  end
  assign sonuc = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                  m9[0] ^ me[1] ^ mb[2] ^ md[3],
                  md[0] ^ m9[1] ^ me[2] ^ mb[3],
                  mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  always_comb begin
    cikis_gecerli = durum == HAZIR;
    giris_hazir = durum == BOS || (durum == HAZIR && cikis_hazir);
    al = giris_gecerli && giris_hazir;
    sonraki = durum;
    case (durum)
      BOS:     sonraki = al ? ISLE : BOS;
      ISLE:    sonraki = sayac == 2'd3 ? HAZIR : ISLE;
      HAZIR:   sonraki = cikis_hazir ? (giris_gecerli ? ISLE : BOS) : HAZIR;
      default: sonraki = BOS;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum <= BOS;
      sayac <= 2'd0;
      is_reg <= '0;
      y_matris <= '0;
    end else begin
      durum <= sonraki;
      if (al) begin
        is_reg <= matris;
        sayac <= 2'd0;
      end else if (durum == ISLE) begin
        y_matris[ust -: 32] <= sonuc;
        sayac <= sayac + 2'd1;
      end
    end
  end
endmodule

// File: doc/ters_sutun_karistirma.md
# ters_sutun_karistirma

Iterative AES InvMixColumns unit for the decryption datapath; the counterpart of the encryption-side column mixing stage. It accepts a 128-bit state through a valid/ready handshake and multiplies each 32-bit column by the inverse MixColumns matrix over GF(2^8). It processes one column per clock and presents the 128-bit result through a valid/ready output handshake. It sits between the inverse round-key addition and inverse shift-rows stages of the decryption round loop.

## Interface
- Parameters: none.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `giris_gecerli`  input  1  input state valid.
- `giris_hazir`  output  1  block can accept a state this cycle.
- `matris`  input  128  input state; column c = bits [127-32c : 96-32c], row byte 0 in the column's MSB byte.
- `cikis_gecerli`  output  1  result valid.
- `cikis_hazir`  input  1  downstream accepts result.
- `y_matris`  output  128  result state, same column/byte layout as `matris`.

## Operation
- Per-column arithmetic, with column bytes s0..s3 and all products in GF(2^8) reduced modulo x^8+x^4+x^3+x+1 (0x11b):
  - y0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - y1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - y2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - y3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- Build the multiples from xtime (x2: shift left 1, XOR 0x1b if the bit shifted out was 1):
  - 09 = x8 ^ x1
  - 0b = x8 ^ x2 ^ x1
  - 0d = x8 ^ x4 ^ x1
  - 0e = x8 ^ x4 ^ x2
  - All values are 8-bit, with no carries.
- Exactly one column-multiply instance is shared across the four columns.
- States:
  - BOS (idle): `giris_hazir`=1. A transfer (`giris_gecerli`&`giris_hazir`) latches `matris` into the work register, clears the column counter to 0 and moves to ISLE.
  - ISLE (busy): each cycle, column[counter] of the work register is transformed and written into the same column of the result register, and the counter increments. After column 3 is written, the state moves to HAZIR. `giris_hazir`=0.
  - HAZIR (result held): `cikis_gecerli`=1 and `giris_hazir`=`cikis_hazir` (combinational).
    - If `cikis_hazir`=1 and `giris_gecerli`=1, the output transfer and a new input transfer occur on the same edge; the state goes to ISLE with the new state latched.
    - If `cikis_hazir`=1 and `giris_gecerli`=0, the state goes to BOS.
    - If `cikis_hazir`=0, the state stays in HAZIR with `y_matris` stable.
- `matris` is sampled only at the transfer edge; later changes have no effect on the state in flight.
- `y_matris` changes only during ISLE; it is stable whenever `cikis_gecerli`=1.
- Asserting `rst_n` mid-operation aborts the state in flight. No partial result is ever flagged valid.

## Timing
- Reset values (during and immediately after `rst_n`=0):
  - state BOS, counter 0, `cikis_gecerli`=0, `y_matris`=0, work register 0.
  - `giris_hazir`=1; no transfer is recognised while `rst_n`=0.
- Latency: input transfer at edge E0; columns 0..3 are written at edges E1..E4; `cikis_gecerli`=1 in the cycle after E4.
- Throughput: with `cikis_hazir` held at 1 and `giris_gecerli` held at 1, one state is accepted every 5 cycles (at E0, E5, E10, ...). `cikis_gecerli` is high for exactly one cycle per state.
- `cikis_gecerli` does not deassert until it is accepted by `cikis_hazir`.
- `giris_hazir` never asserts during ISLE.
- The counter is 2 bits. It wraps from 3 to 0 when leaving ISLE, and the wrap value is unused.

## Test plan
- FIPS-197 vector: `matris`=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> `y_matris`=db135345_f20a225c_01010101_c6c6c6c6 with `cikis_gecerli` rising 4 cycles after the accept edge.
- Second vector with `cikis_hazir`=0 for 10 cycles: `matris`=d5d5d7d6_4d7ebdf8_00000000_ffffffff -> `y_matris`=d4d4d4d5_2d26314c_00000000_ffffffff. Output and `cikis_gecerli` hold unchanged for all 10 cycles; `giris_hazir`=0 throughout.
- Back-to-back: `giris_gecerli` and `cikis_hazir` held at 1 with two states queued. The second accept coincides with the first output transfer (5-cycle spacing), and both results are correct.
- Input hold-off: change `matris` to random values every cycle during ISLE; the result still equals the transform of the value latched at the accept edge.
- Round trip: 1000 random states run through a reference MixColumns model and then through the DUT; every output equals the original state.
- Reset mid-operation: drop `rst_n` at edge E2. Immediately `cikis_gecerli`=0, `y_matris`=0 and state BOS. After release, a fresh vector completes correctly with normal 4-cycle latency.
